// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between multicycle_controller and datapath
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       bge;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero, bge,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal
    );

    modport slave (
        output op, funct, zero, bge,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle datapath sequencer (lw/sw/R/beq/bge/addi/j)
module multicycle_controller #(
    parameter logic [5:0] OP_BGE = 6'b000001
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master ctl
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        BGE     = 4'd12
    } state_t;

    state_t     st;
    logic [2:0] alu_fn;
    logic       funct_ok;
    logic       op_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (ctl.funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        if (ctl.op == OP_LW || ctl.op == OP_SW || ctl.op == OP_BEQ || ctl.op == OP_BGE ||
            ctl.op == OP_ADDI || ctl.op == OP_J || (ctl.op == OP_RTYPE && funct_ok))
            op_ok = 1'b1;
    end

    // funct is captured at DECODE so EXECUTE is immune to the IR changing underneath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= FETCH;
            alu_fn <= 3'b010;
        end else begin
            case (st)
                FETCH:   st <= DECODE;
                DECODE: begin
                    alu_fn <= funct_alu;
                    if (!op_ok)                  st <= FETCH;
                    else if (ctl.op == OP_LW || ctl.op == OP_SW) st <= MEMADR;
                    else if (ctl.op == OP_RTYPE) st <= EXECUTE;
                    else if (ctl.op == OP_BEQ)   st <= BEQ;
                    else if (ctl.op == OP_BGE)   st <= BGE;
                    else if (ctl.op == OP_ADDI)  st <= ADDIEX;
                    else                         st <= JUMP;
                end
                MEMADR:  st <= (ctl.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   st <= MEMWB;
                EXECUTE: st <= ALUWB;
                ADDIEX:  st <= ADDIWB;
                default: st <= FETCH;
            endcase
        end
    end

    always_comb begin
        ctl.pcen       = 1'b0;
        ctl.iord       = 1'b0;
        ctl.memwrite   = 1'b0;
        ctl.irwrite    = 1'b0;
        ctl.regdst     = 1'b0;
        ctl.memtoreg   = 1'b0;
        ctl.regwrite   = 1'b0;
        ctl.alusrca    = 1'b0;
        ctl.alusrcb    = 2'b00;
        ctl.pcsrc      = 2'b00;
        ctl.alucontrol = 3'b010;
        ctl.illegal    = 1'b0;
        ctl.state      = st;
        case (st)
            FETCH: begin
                ctl.irwrite = 1'b1;
                ctl.alusrcb = 2'b01;
                ctl.pcen    = 1'b1;
            end
            DECODE: begin
                ctl.alusrcb = 2'b11;
                ctl.illegal = !op_ok;
            end
            MEMADR, ADDIEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
            end
            MEMRD: ctl.iord = 1'b1;
            MEMWB: begin
                ctl.memtoreg = 1'b1;
                ctl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctl.iord     = 1'b1;
                ctl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctl.alusrca    = 1'b1;
                ctl.alucontrol = alu_fn;
            end
            ALUWB: begin
                ctl.regdst   = 1'b1;
                ctl.regwrite = 1'b1;
            end
            ADDIWB: ctl.regwrite = 1'b1;
            BEQ, BGE: begin
                ctl.alusrca    = 1'b1;
                ctl.alucontrol = 3'b110;
                ctl.pcsrc      = 2'b01;
                ctl.pcen       = (st == BEQ) ? ctl.zero : ctl.bge;
            end
            JUMP: begin
                ctl.pcsrc = 2'b10;
                ctl.pcen  = 1'b1;
            end
            default: ;
        endcase
        // reset holds FETCH selects but suppresses every state-changing strobe
        if (!reset) begin
            ctl.pcen     = 1'b0;
            ctl.irwrite  = 1'b0;
            ctl.regwrite = 1'b0;
            ctl.memwrite = 1'b0;
            ctl.illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    localparam logic [5:0] OP_BGE = 6'b000001;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_RBAD = 3, K_BEQ = 4,
                   K_BGE = 5, K_ADDI = 6, K_J = 7, K_BADOP = 8;

    logic clk;
    logic reset;
    multicycle_controller_if bus();

    multicycle_controller #(.OP_BGE(OP_BGE)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [5:0] good_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] good_alu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    function automatic vec_t blank(input int s);
        vec_t v;
        v      = '0;
        v.aluc = 3'b010;
        v.st   = s[3:0];
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v         = blank(0);
        v.alusrcb = 2'b01;
        return v;
    endfunction

    // expected control word for one cycle of a given state, from the state table
    function automatic vec_t expect_for(input int s, input logic z, input logic b,
                                        input logic ill, input logic [2:0] fn);
        vec_t v;
        v = blank(s);
        case (s)
            0:  begin v.irwrite = 1; v.alusrcb = 2'b01; v.pcen = 1; end
            1:  begin v.alusrcb = 2'b11; v.illegal = ill; end
            2, 9: begin v.alusrca = 1; v.alusrcb = 2'b10; end
            3:  v.iord = 1;
            4:  begin v.memtoreg = 1; v.regwrite = 1; end
            5:  begin v.iord = 1; v.memwrite = 1; end
            6:  begin v.alusrca = 1; v.aluc = fn; end
            7:  begin v.regdst = 1; v.regwrite = 1; end
            10: v.regwrite = 1;
            8, 12: begin
                v.alusrca = 1; v.aluc = 3'b110; v.pcsrc = 2'b01;
                v.pcen = (s == 8) ? z : b;
            end
            11: begin v.pcsrc = 2'b10; v.pcen = 1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic cyc(input vec_t e);
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run_instr(input int kind, input int abort_at);
        logic [5:0] o, f;
        logic [2:0] fn;
        logic       ill;
        int         path[$];
        int         k;
        ill = 1'b0;
        fn  = 3'b010;
        f   = 6'($urandom);
        o   = 6'b0;
        case (kind)
            K_LW:   begin o = 6'b100011; path = '{1, 2, 3, 4}; end
            K_SW:   begin o = 6'b101011; path = '{1, 2, 5}; end
            K_R: begin
                k = $urandom_range(0, 4);
                o = 6'b0; f = good_funct[k]; fn = good_alu[k]; path = '{1, 6, 7};
            end
            K_RBAD: begin
                o = 6'b0; ill = 1'b1; path = '{1};
                while (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                       f == 6'b100101 || f == 6'b101010) f = 6'($urandom);
            end
            K_BEQ:  begin o = 6'b000100; path = '{1, 8}; end
            K_BGE:  begin o = OP_BGE;    path = '{1, 12}; end
            K_ADDI: begin o = 6'b001000; path = '{1, 9, 10}; end
            K_J:    begin o = 6'b000010; path = '{1, 11}; end
            default: begin
                ill = 1'b1; path = '{1};
                o = 6'($urandom);
                while (o == 6'b100011 || o == 6'b101011 || o == 6'b0 || o == 6'b000100 ||
                       o == OP_BGE || o == 6'b001000 || o == 6'b000010) o = 6'($urandom);
            end
        endcase
        reset     = 1'b1;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = 1'($urandom);
        bus.bge   = 1'($urandom);
        cyc(expect_for(0, bus.zero, bus.bge, ill, fn));
        foreach (path[i]) begin
            if (i == abort_at) begin
                reset = 1'b0;
                cyc(reset_vec());
                cyc(reset_vec());
                reset = 1'b1;
                return;
            end
            bus.zero = 1'($urandom);
            bus.bge  = 1'($urandom);
            if (path[i] != 1) bus.funct = 6'($urandom);
            cyc(expect_for(path[i], bus.zero, bus.bge, ill, fn));
        end
    endtask

    initial begin : monitor
        vec_t e, a;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e          = q.pop_front();
                a.st       = bus.state;
                a.pcen     = bus.pcen;
                a.iord     = bus.iord;
                a.memwrite = bus.memwrite;
                a.irwrite  = bus.irwrite;
                a.regdst   = bus.regdst;
                a.memtoreg = bus.memtoreg;
                a.regwrite = bus.regwrite;
                a.alusrca  = bus.alusrca;
                a.alusrcb  = bus.alusrcb;
                a.pcsrc    = bus.pcsrc;
                a.aluc     = bus.alucontrol;
                a.illegal  = bus.illegal;
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL ctrl_word t=%0t exp_state=%0d got=%05h want=%05h",
                             $time, e.st, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        reset     = 1'b0;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        bus.bge   = 1'b0;
        @(negedge clk);
        #1;
        repeat (3) cyc(reset_vec());
        for (int k = 0; k <= K_BADOP; k++) run_instr(k, -1);
        run_instr(K_LW, 2);
        run_instr(K_RBAD, -1);
        repeat (400)
            run_instr($urandom_range(0, K_BADOP),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
        @(negedge clk);
        #5;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
